// File: rtl/nes_dma_pkg.sv
// ============================================================================
// Module  : nes_dma_pkg
// Brief   : Shared state encoding and address constants for the OAM DMA engine.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package nes_dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        RD    = 3'd3,
        WR    = 3'd4
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR_C  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_C = 16'h2004;
    localparam int          XFER_LEN_C      = 256;

endpackage

`default_nettype wire

// File: rtl/dma_bus_mux.sv
// ============================================================================
// Module  : dma_bus_mux
// Brief   : Selects CPU or DMA address/data/strobe onto the memory bus.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dma_bus_mux #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              i_sel_dma,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_wdata,
    input  logic              i_dma_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we
);

    assign o_mem_addr  = i_sel_dma ? i_dma_addr  : i_cpu_addr;
    assign o_mem_wdata = i_sel_dma ? i_dma_wdata : i_cpu_wdata;
    assign o_mem_we    = i_sel_dma ? i_dma_we    : i_cpu_we;

endmodule

`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
// ============================================================================
// Module  : oam_dma_ctrl
// Brief   : Sprite DMA bus owner: on a $4014 write, halts the CPU and copies
//           page:00..page:FF to the OAM data port. Optional macro
//           OAM_DMA_ODD_ALIGN_EN adds the odd-cycle ALIGN dummy cycle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module oam_dma_ctrl
    import nes_dma_pkg::*;
#(
    parameter int               ADDR_W        = 16,
    parameter int               DATA_W        = 8,
    parameter logic [ADDR_W-1:0] DMA_REG_ADDR  = DMA_REG_ADDR_C,
    parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = OAM_DATA_ADDR_C,
    parameter int               XFER_LEN      = XFER_LEN_C
) (
    input  logic              clk,
    input  logic              b_rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic              cpu_rdy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dma_busy
);

    localparam logic [7:0] c_last_idx = 8'(XFER_LEN - 1);

    dma_state_t        r_state;
    dma_state_t        w_state_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_nxt;
    logic [7:0]        r_page;
    logic              w_load_page;
    logic              w_busy;
    logic [ADDR_W-1:0] w_dma_addr;
    logic [DATA_W-1:0] w_dma_wdata;
    logic              w_dma_we;

`ifdef OAM_DMA_ODD_ALIGN_EN
    logic r_parity;

    always_ff @(posedge clk or posedge b_rst) begin
        if (b_rst) r_parity <= 1'b0;
        else       r_parity <= ~r_parity;
    end
`endif

    always_ff @(posedge clk or posedge b_rst) begin
        if (b_rst) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_page  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load_page) r_page <= cpu_wdata[7:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_page = 1'b0;
        w_busy      = 1'b1;
        w_dma_addr  = cpu_addr;
        w_dma_wdata = '0;
        w_dma_we    = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
                    w_load_page = 1'b1;
                    w_state_nxt = HALT;
                end
            end
            HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                w_state_nxt = r_parity ? ALIGN : RD;
`else
                w_state_nxt = RD;
`endif
            end
            ALIGN: w_state_nxt = RD;
            RD: begin
                w_dma_addr  = ADDR_W'({r_page, r_cnt});
                w_state_nxt = WR;
            end
            WR: begin
                // Read data from the RD address arrives this cycle.
                w_dma_addr  = OAM_DATA_ADDR;
                w_dma_wdata = mem_rdata;
                w_dma_we    = 1'b1;
                if (r_cnt == c_last_idx) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                    w_state_nxt = RD;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign dma_busy = w_busy;
    assign cpu_rdy  = ~w_busy;

    dma_bus_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bus_mux (
        .i_sel_dma   (w_busy),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .i_cpu_we    (cpu_we),
        .i_dma_addr  (w_dma_addr),
        .i_dma_wdata (w_dma_wdata),
        .i_dma_we    (w_dma_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_we    (mem_we)
    );

endmodule

`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
// ============================================================================
// Module  : tb_oam_dma_ctrl
// Brief   : Scoreboard bench for oam_dma_ctrl; honours OAM_DMA_ODD_ALIGN_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_oam_dma_ctrl;

    logic        clk;
    logic        b_rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        dma_busy;

    typedef struct {
        logic [15:0] rd_addr;
        logic [7:0]  data;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          stall_cnt = 0;
    int          wr_count = 0;
    logic [31:0] cyc;
    logic [15:0] prev_addr = 16'h0;

    oam_dma_ctrl u_dut (
        .clk       (clk),
        .b_rst     (b_rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdy   (cpu_rdy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .dma_busy  (dma_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Page $02 yields index^5A; other pages fold the page in so sources differ.
    function automatic logic [7:0] rd_model(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
    endfunction

    always @(posedge clk) mem_rdata <= rd_model(mem_addr);

    always @(posedge clk or posedge b_rst) begin
        if (b_rst) cyc <= 32'd0;
        else       cyc <= cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!b_rst) begin
            if (!cpu_rdy) stall_cnt++;
            if (dma_busy && mem_we) begin
                wr_count++;
                if (sb.size() == 0) begin
                    chk("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rd_addr", {16'h0, prev_addr}, {16'h0, e.rd_addr});
                    chk("wr_addr", {16'h0, mem_addr}, 32'h2004);
                    chk("wr_data", {24'h0, mem_wdata}, {24'h0, e.data});
                end
            end
            if (!dma_busy) chk("idle_we", {31'h0, mem_we}, {31'h0, cpu_we});
            chk("rdy_vs_busy", {31'h0, cpu_rdy}, {31'h0, ~dma_busy});
            prev_addr = mem_addr;
        end
    end

    function automatic int exp_stall(input bit halt_par);
`ifdef OAM_DMA_ODD_ALIGN_EN
        return halt_par ? 514 : 513;
`else
        return 513;
`endif
    endfunction

    // Called at a falling edge; hp_sel 0/1 forces HALT-cycle parity, 2 = now.
    task automatic xfer_start(input logic [7:0] page, input int hp_sel, output int stall_exp);
        #2;
        if (hp_sel != 2 && int'(~cyc[0]) != hp_sel) begin
            @(negedge clk);
            #2;
        end
        stall_exp = exp_stall(~cyc[0]);
        stall_cnt = 0;
        wr_count  = 0;
        for (int i = 0; i < 256; i++) begin
            exp_t e;
            e.rd_addr = {page, 8'(i)};
            e.data    = rd_model({page, 8'(i)});
            sb.push_back(e);
        end
        cpu_addr  = 16'h4014;
        cpu_wdata = page;
        cpu_we    = 1'b1;
        @(negedge clk);
        #2;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    task automatic xfer_wait(input string tag, input int stall_exp);
        int n = 0;
        while (dma_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, (n < 2000) ? 32'd1 : 32'd0, 32'd1);
        chk({tag, "_stall"}, stall_cnt, stall_exp);
        chk({tag, "_wrcount"}, wr_count, 32'd256);
        chk({tag, "_sb_empty"}, sb.size(), 32'd0);
        chk({tag, "_rdy_after"}, {31'h0, cpu_rdy}, 32'd1);
    endtask

    task automatic idle_gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int se;
        int se2;
        int n;
        b_rst     = 1'b1;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", {31'h0, cpu_rdy}, 32'd1);
        chk("rst_busy", {31'h0, dma_busy}, 32'd0);
        b_rst    = 1'b0;
        cpu_addr = 16'h1234;
        #1;
        chk("rst_pass_addr", {16'h0, mem_addr}, 32'h1234);
        cpu_addr = 16'h0000;
        idle_gap(2);

        xfer_start(8'h02, 0, se);
        xfer_wait("even", se);
        idle_gap(3);

        xfer_start(8'h02, 1, se);
        xfer_wait("odd", se);
        idle_gap(3);

        xfer_start(8'hFF, 2, se);
        xfer_wait("pageFF", se);
        idle_gap(3);

        // Retrigger attempt while busy must be ignored.
        xfer_start(8'h02, 2, se);
        idle_gap(50);
        #2;
        cpu_addr  = 16'h4014;
        cpu_wdata = 8'h03;
        cpu_we    = 1'b1;
        @(negedge clk);
        #2;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        xfer_wait("retrig", se);
        idle_gap(3);
        chk("retrig_no_restart", {31'h0, dma_busy}, 32'd0);

        // Reset mid-transfer.
        xfer_start(8'h02, 2, se);
        n = 0;
        while (wr_count < 100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reach", (n < 1000) ? 32'd1 : 32'd0, 32'd1);
        #2;
        b_rst = 1'b1;
        #1;
        chk("rst_mid_rdy", {31'h0, cpu_rdy}, 32'd1);
        chk("rst_mid_busy", {31'h0, dma_busy}, 32'd0);
        chk("rst_mid_we", {31'h0, mem_we}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        chk("rst_hold_we", {31'h0, mem_we}, 32'd0);
        @(negedge clk);
        b_rst = 1'b0;
        idle_gap(3);
        chk("post_rst_busy", {31'h0, dma_busy}, 32'd0);
        xfer_start(8'h02, 2, se);
        xfer_wait("after_rst", se);

        // Back-to-back: second trigger in the first IDLE cycle.
        idle_gap(2);
        xfer_start(8'h02, 2, se);
        xfer_wait("b2b_first", se);
        xfer_start(8'h10, 2, se2);
        chk("b2b_started", {31'h0, dma_busy}, 32'd1);
        xfer_wait("b2b_second", se2);
        idle_gap(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
